fir_dec_fifo: RTL and testbench

- Downstream of the N-tap FIR. Consumes the FIR output stream (signal_out qualified by the one-cycle valid_out pulse).
- Optionally decimates that stream by a runtime factor, then buffers the kept samples in a first-word-fall-through FIFO.
- Exposes the buffered samples on a ready/valid master port for the next consumer (DMA, serializer or ARM-side register reader).
- Absorbs bursty consumer back-pressure, because the FIR has no stall input.

---
 rtl/fir_dec_fifo.sv | 111 +++++++++++
 tb/tb_fir_dec_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_dec_fifo.sv
// Runtime decimator followed by a first-word-fall-through FIFO with a ready/valid master port.
// Optional macro FIR_DEC_FIFO_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module fir_dec_fifo #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int DEC_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEC_W-1:0]      dec_factor,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int                DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEC_W-1:0]      r_phase;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic w_keep;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    // A valid_in during flush is ignored entirely: no keep, no drop, no phase step.
    assign w_keep = valid_in & ~flush & (r_phase == '0);
    assign w_full = (r_count == L_FULL);
    assign w_pop  = m_valid & m_ready;
    assign w_push = w_keep & (~w_full | w_pop);
    assign w_drop = w_keep & w_full & ~w_pop;

    assign m_valid  = (r_count != '0);
    assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
    assign count    = r_count;
    assign full     = w_full;
    assign overflow = r_overflow;

    // NOTE: storage has no reset; empty-state output is forced to zero by m_valid gating instead.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_phase  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // >= rather than == so a lowered dec_factor wraps immediately.
            if (valid_in) begin
                r_phase <= (r_phase >= dec_factor) ? '0 : r_phase + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef FIR_DEC_FIFO_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_fir_dec_fifo.sv
// Scoreboard bench for fir_dec_fifo: expected samples are queued at stimulus time and
// compared whenever the master port hands one over.
module tb_fir_dec_fifo;

    localparam int DATA_W     = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEC_W      = 4;

    logic                clk;
    logic                rst;
    logic [DEC_W-1:0]    dec_factor;
    logic                flush;
    logic                valid_in;
    logic [DATA_W-1:0]   data_in;
    logic                m_valid;
    logic [DATA_W-1:0]   m_data;
    logic                m_ready;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                overflow;
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
    logic [15:0]         drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] sb[$];

    fir_dec_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .DEC_W     (DEC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_factor(dec_factor),
        .flush     (flush),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got m_data=%h, required no output", m_data);
            end else begin
                logic [DATA_W-1:0] exp_d;
                exp_d = sb.pop_front();
                if (m_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL sb_data: got m_data=%h, required %h", m_data, exp_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d samples outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        n_checks++;
        if (m_data !== '0) begin n_fail++; $display("FAIL rst_m_data: got %h, required 0000", m_data); end
        n_checks++;
        if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", count); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b, required 0", full); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop_count: got %0d, required 0", drop_count); end
`endif
    endtask

    task automatic test_pass_through();
        tick();
        dec_factor = '0;
        m_ready    = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(DATA_W'(i));
            valid_in = 1'b1;
            data_in  = DATA_W'(i);
            tick();
            valid_in = 1'b0;
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== DATA_W'(i)) begin
                n_fail++;
                $display("FAIL pass_latency: got m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, DATA_W'(i));
            end
            n_checks++;
            if (count !== 1) begin n_fail++; $display("FAIL pass_count_hold: got %0d, required 1", count); end
            tick();
            @(negedge clk);
            n_checks++;
            if (count !== 0 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pass_count_after_pop: got count=%0d m_valid=%b, required 0 0", count, m_valid);
            end
            repeat (3) tick();
        end
        drain("pass");
    endtask

    task automatic test_decimate();
        tick();
        dec_factor = 4'd3;
        m_ready    = 1'b1;
        sb.push_back(16'h0010);
        sb.push_back(16'h0014);
        sb.push_back(16'h0018);
        for (int i = 0; i < 12; i++) begin
            valid_in = 1'b1;
            data_in  = DATA_W'(16'h0010 + i);
            tick();
        end
        valid_in = 1'b0;
        repeat (3) tick();
        drain("decim");
        n_checks++;
        if (count !== 0) begin n_fail++; $display("FAIL decim_count: got %0d, required 0", count); end
    endtask

    task automatic test_overflow();
        tick();
        dec_factor = '0;
        m_ready    = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(DATA_W'(16'h0100 + i));
            valid_in = 1'b1;
            data_in  = DATA_W'(16'h0100 + i);
            tick();
        end
        valid_in = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (count !== 16) begin n_fail++; $display("FAIL ovf_count: got %0d, required 16", count); end
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b, required 1", full); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        n_checks++;
        if (m_data !== 16'h0100) begin n_fail++; $display("FAIL ovf_head_stable: got %h, required 0100", m_data); end
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_count !== 16'd1) begin n_fail++; $display("FAIL ovf_drop_count: got %0d, required 1", drop_count); end
`endif
        tick();
        m_ready = 1'b1;
        drain("ovf");
        repeat (2) tick();
        n_checks++;
        if (count !== 0) begin n_fail++; $display("FAIL ovf_empty: got count=%0d, required 0", count); end
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back_full();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dec_factor = '0;
        m_ready    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back(DATA_W'(16'h0200 + i));
            valid_in = 1'b1;
            data_in  = DATA_W'(16'h0200 + i);
            tick();
        end
        valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pre_full: got full=%b overflow=%b, required 1 0", full, overflow);
        end
        tick();
        sb.push_back(16'h0300);
        valid_in = 1'b1;
        data_in  = 16'h0300;
        m_ready  = 1'b1;
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d, required 16", count); end
        drain("b2b");
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b, required 0", overflow); end
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_count !== 16'd0) begin n_fail++; $display("FAIL b2b_drop_count: got %0d, required 0", drop_count); end
`endif
        m_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        tick();
        dec_factor = '0;
        m_ready    = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(DATA_W'(16'h0500 + i));
            valid_in = 1'b1;
            data_in  = DATA_W'(16'h0500 + i);
            tick();
        end
        valid_in = 1'b0;
        m_ready  = 1'b1;
        repeat (12) tick();
        m_ready = 1'b0;
        // Leave phase at 1 so the flush must visibly restart it.
        dec_factor = 4'd2;
        sb.push_back(16'h0600);
        valid_in = 1'b1;
        data_in  = 16'h0600;
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 5 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got count=%0d overflow=%b, required 5 1", count, overflow);
        end
        tick();
        flush    = 1'b1;
        valid_in = 1'b1;
        data_in  = 16'hDEAD;
        tick();
        flush    = 1'b0;
        valid_in = 1'b0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (count !== 0 || m_valid !== 1'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL flush_clear: got count=%0d m_valid=%b m_data=%h, required 0 0 0000", count, m_valid, m_data);
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL flush_overflow_held: got %b, required 1", overflow); end
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_count !== 16'd1) begin n_fail++; $display("FAIL flush_drop_count_held: got %0d, required 1", drop_count); end
`endif
        tick();
        valid_in = 1'b1;
        data_in  = 16'h0400;
        tick();
        data_in  = 16'h0401;
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 1 || m_data !== 16'h0400) begin
            n_fail++;
            $display("FAIL flush_phase_restart: got count=%0d m_data=%h, required 1 0400", count, m_data);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b0 || count !== 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_op: got overflow=%b count=%0d m_valid=%b, required 0 0 0", overflow, count, m_valid);
        end
`ifdef FIR_DEC_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_drop_count: got %0d, required 0", drop_count); end
`endif
    endtask

    initial begin
        rst        = 1'b0;
        dec_factor = '0;
        flush      = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        m_ready    = 1'b0;
        test_reset();
        test_pass_through();
        test_decimate();
        test_overflow();
        test_back_to_back_full();
        test_flush_reset();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
